// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. One full-adder stage and a carry flip-flop
//   process the operands LSB first, one bit per clock. A transaction takes
//   WIDTH cycles in RUN followed by one DONE cycle that presents the result.
//
// Parameters
//   WIDTH  operand/result width in bits (1..32)
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  begin an addition (accepted in IDLE or DONE, ignored in RUN)
//   a, b   operands, sampled only when start is accepted
//   busy   high while the serial addition is running
//   done   one-cycle pulse when a new result is on sum/cout
//   sum    a + b modulo 2^WIDTH (held between results)
//   cout   carry out of bit WIDTH-1 (held between results)
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter needs at least one bit even when WIDTH == 1.
    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] work_shifted;

    // Full-adder stage on the current LSBs; the new sum bit enters the
    // working register from the MSB end so that after WIDTH shifts the
    // result is aligned.
    always_comb begin
        bit_s        = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c        = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        work_shifted = (work_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b;
                    work_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // start is deliberately not looked at here.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                work_d  = work_shifted;
                carry_d = bit_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    sum_d   = work_shifted;
                    cout_d  = bit_c;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs are decodes of, or copies of, registers.
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  first operand, unsigned; sampled only on an accepted start.
REQ-006 Port: b  input  WIDTH  second operand, unsigned; sampled only on an accepted start.
REQ-007 Port: busy  output  1  high while a serial addition is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking a new valid result.
REQ-009 Port: sum  output  WIDTH  result a+b modulo 2^WIDTH.
REQ-010 Port: cout  output  1  carry out of bit WIDTH-1.
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-012 The block SHALL be a bit-serial adder: one full-adder stage (s = x^y^c, c' = x&y | x&c | y&c) plus one carry flip-flop, processing one bit per cycle, LSB first.
REQ-013 State machine SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge -> latch a, b into shift registers, clear carry FF, clear bit counter to 0, go to RUN; start=0 -> stay IDLE.
REQ-015 RUN: each edge computes one sum bit from the current LSBs of the operand shift registers and the carry FF, shifts both operand registers right by one, shifts the sum bit into a working register from the MSB end, updates the carry FF, and increments the counter.
REQ-016 RUN -> DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1); on that same edge sum and cout SHALL be loaded with the completed working result and final carry.
REQ-017 DONE SHALL last exactly one cycle; in it done=1; next state is RUN if start=1 (new operands accepted as in REQ-014), else IDLE.
REQ-018 Latency: start accepted at edge k -> busy=1 after edges k..k+WIDTH-1, done=1 and new sum/cout visible after edge k+WIDTH; throughput one addition per WIDTH+1 cycles with start held high.
REQ-019 busy SHALL be 1 exactly when state is RUN; done SHALL be 1 exactly when state is DONE.
REQ-020 start asserted while in RUN SHALL be ignored: no operand reload, no counter reset, no effect on the result.
REQ-021 Changes on a and b outside an accepted start SHALL not affect the computation in progress.
REQ-022 sum and cout SHALL hold the previous result unchanged throughout RUN and IDLE; they update only on the edge entering DONE.
REQ-023 Arithmetic SHALL be unsigned; {cout, sum} SHALL equal a + b exactly as a WIDTH+1-bit value.
REQ-024 WIDTH=1 SHALL work: RUN lasts one cycle, done after edge k+1.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, counter=0, operand and working registers=0.
REQ-026 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for the aborted addition after rst deasserts.
REQ-027 start sampled on the first rising edge after rst deasserts SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, start with a=0x00, b=0x00 -> busy high 8 cycles, done pulse after edge k+8, sum=0x00, cout=0.
REQ-029 a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0x5A, b=0x25 -> sum=0x7F, cout=0; a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-030 Start a=0x10, b=0x20; at edge k+3 pulse start with a=0xFF, b=0xFF -> ignored, result sum=0x30, cout=0 at edge k+8.
REQ-031 Start a=0x80, b=0x80, assert rst asynchronously mid-cycle at k+4 -> busy, done, sum, cout read 0 before next clk edge; no done pulse after release.
REQ-032 Hold start=1 continuously with a=0x01, b=0x02 then a=0x03, b=0x04 changed during first RUN -> done every 9 cycles; first sum=0x03, second operands captured in DONE cycle give sum=0x07.
REQ-033 Random self-check: 1000 random operand pairs at WIDTH=8 and WIDTH=1, each {cout,sum} compared against a+b; sum/cout stable between done pulses.
